// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the LCD refresh sequencer.
// The HD44780 command set and the write-list lengths live here.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int INIT_LEN  = 4;
  localparam int PASS_LEN  = 34;
  localparam int BUF_DEPTH = 32;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_PWR_WAIT = 3'd0;
  localparam lcd_state_t ST_LOAD     = 3'd1;
  localparam lcd_state_t ST_ISSUE    = 3'd2;
  localparam lcd_state_t ST_WAIT_LO  = 3'd3;
  localparam lcd_state_t ST_WAIT_HI  = 3'd4;
  localparam lcd_state_t ST_DELAY    = 3'd5;
  localparam lcd_state_t ST_IDLE     = 3'd6;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return CLEAR;
      default: return ENTRY_MODE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Byte handshake between the sequencer (master) and the LCD write controller (slave).
interface lcd_sequencer_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_start;
  logic       lcd_done;

  modport master (output lcd_data, output lcd_rs, output lcd_start, input lcd_done);
  modport slave  (input lcd_data, input lcd_rs, input lcd_start, output lcd_done);
endinterface

// File: rtl/lcd_char_buffer.sv
// 32x8 character buffer: synchronous write, asynchronous read, resets to spaces.
module lcd_char_buffer
  import lcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= CHAR_SPACE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 init + display refresh sequencer feeding the LCD write controller.
//   state    | meaning
//   PWR_WAIT | power-up settle delay after reset
//   LOAD     | latch next byte/rs from the step index
//   ISSUE    | one-cycle start pulse
//   WAIT_LO  | wait for done to drop (controller accepted)
//   WAIT_HI  | wait for done to return high
//   DELAY    | execution delay, longer after CLEAR
//   IDLE     | display up to date, waiting for refresh
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_DELAY = 750000,
  parameter int CMD_DELAY     = 2000,
  parameter int CLEAR_DELAY   = 82000,
  parameter int CNT_W         = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             refresh,
  output logic             busy,
  output logic             init_done,
  lcd_sequencer_if.master  lcd
);

  lcd_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] delay_end;
  logic [5:0]       step;
  logic             in_init;
  logic             pending;
  logic             last_step;
  logic [4:0]       rd_addr;
  logic [7:0]       rd_data;
  lcd_byte_t        nxt;

  lcd_char_buffer u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Pass layout: 0 = line-1 addr, 1..16 = buf[0..15], 17 = line-2 addr, 18..33 = buf[16..31]
  always_comb begin
    rd_addr = '0;
    if (step >= 6'd18)     rd_addr = 5'(step - 6'd2);
    else if (step >= 6'd1) rd_addr = 5'(step - 6'd1);
  end

  always_comb begin
    nxt.rs   = 1'b0;
    nxt.data = 8'h00;
    if (in_init) begin
      nxt.data = init_cmd(step[1:0]);
    end else if (step == 6'd0) begin
      nxt.data = LINE1_ADDR;
    end else if (step == 6'd17) begin
      nxt.data = LINE2_ADDR;
    end else begin
      nxt.rs   = 1'b1;
      nxt.data = rd_data;
    end
  end

  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign delay_end = (lcd.lcd_data == CLEAR && !lcd.lcd_rs) ? CNT_W'(CLEAR_DELAY - 1)
                                                            : CNT_W'(CMD_DELAY - 1);
  assign last_step = in_init ? (step == 6'(INIT_LEN - 1)) : (step == 6'(PASS_LEN - 1));

  assign busy          = (state != ST_IDLE);
  assign lcd.lcd_start = (state == ST_ISSUE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_PWR_WAIT;
      cnt          <= '0;
      step         <= '0;
      in_init      <= 1'b1;
      pending      <= 1'b0;
      init_done    <= 1'b0;
      lcd.lcd_data <= 8'h00;
      lcd.lcd_rs   <= 1'b0;
    end else begin
      // Counter only survives while staying in a counting state.
      cnt <= '0;
      if (refresh && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_PWR_WAIT: begin
          if (cnt == CNT_W'(POWERUP_DELAY - 1)) state <= ST_LOAD;
          else                                  cnt   <= cnt_inc;
        end
        ST_LOAD: begin
          lcd.lcd_data <= nxt.data;
          lcd.lcd_rs   <= nxt.rs;
          state        <= ST_ISSUE;
        end
        ST_ISSUE:   state <= ST_WAIT_LO;
        ST_WAIT_LO: if (!lcd.lcd_done) state <= ST_WAIT_HI;
        ST_WAIT_HI: if (lcd.lcd_done)  state <= ST_DELAY;
        ST_DELAY: begin
          if (cnt != delay_end) begin
            cnt <= cnt_inc;
          end else if (!last_step) begin
            step  <= step + 6'd1;
            state <= ST_LOAD;
          end else begin
            step <= '0;
            if (in_init) begin
              in_init   <= 1'b0;
              init_done <= 1'b1;
              state     <= ST_LOAD;
            end else if (pending || refresh) begin
              // A request landing on the final cycle still earns a pass.
              pending <= 1'b0;
              state   <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (refresh) begin
            step  <= '0;
            state <= ST_LOAD;
          end
        end
        default: state <= ST_PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a behavioural LCD controller that logs every start.
module tb_lcd_sequencer;
  import lcd_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       refresh = 1'b0;
  logic       busy;
  logic       init_done;

  lcd_sequencer_if lcd_bus ();

  lcd_sequencer #(
    .POWERUP_DELAY (10),
    .CMD_DELAY     (3),
    .CLEAR_DELAY   (8),
    .CNT_W         (20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .refresh   (refresh),
    .busy      (busy),
    .init_done (init_done),
    .lcd       (lcd_bus.master)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dcnt    = 0;

  logic [8:0] log_q [$];
  int         log_cyc [$];
  bit         log_init [$];
  logic [7:0] model_buf [32];
  logic [7:0] init_exp [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Controller model: done drops on start, returns high 4 cycles later.
  initial lcd_bus.lcd_done = 1'b1;
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      lcd_bus.lcd_done = 1'b1;
      dcnt = 0;
    end else if (lcd_bus.lcd_start) begin
      log_q.push_back({lcd_bus.lcd_rs, lcd_bus.lcd_data});
      log_cyc.push_back(cyc);
      log_init.push_back(init_done);
      lcd_bus.lcd_done = 1'b0;
      dcnt = 4;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) lcd_bus.lcd_done = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_pass(input int i);
    if (i == 0)  return {1'b0, 8'h80};
    if (i == 17) return {1'b0, 8'hC0};
    if (i < 17)  return {1'b1, model_buf[i-1]};
    return {1'b1, model_buf[i-2]};
  endfunction

  function automatic logic [8:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 9'h1FF;
  endfunction

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
    log_init.delete();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < max);
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_log(input int cnt, input int max);
    int n = 0;
    while (log_q.size() < cnt && n < max) begin
      @(negedge clock);
      n++;
    end
    chk("log_reached", log_q.size() >= cnt, 1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
    model_buf[a] = d;
  endtask

  task automatic pulse_refresh();
    @(negedge clock);
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
  endtask

  task automatic check_pass(input int base, input string tag);
    for (int i = 0; i < PASS_LEN; i++)
      chk($sformatf("%s[%0d]", tag, i), log_at(base + i), exp_pass(i));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  busy, 1);
    chk({tag, "_initd"}, init_done, 0);
    chk({tag, "_start"}, lcd_bus.lcd_start, 0);
    chk({tag, "_data"},  lcd_bus.lcd_data, 8'h00);
    chk({tag, "_rs"},    lcd_bus.lcd_rs, 0);
  endtask

  task automatic check_init_and_pass(input string tag);
    chk({tag, "_count"}, log_q.size(), 38);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_init[%0d]", tag, i), log_at(i), {1'b0, init_exp[i]});
    if (log_q.size() >= 5) begin
      chk({tag, "_clear_gap"}, (log_cyc[3] - log_cyc[2]) - (log_cyc[2] - log_cyc[1]), 5);
      chk({tag, "_initd_at_06"}, log_init[3], 0);
      chk({tag, "_initd_at_80"}, log_init[4], 1);
    end
    check_pass(4, {tag, "_auto"});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;

    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Power-up init followed by the automatic pass of spaces.
    wait_idle(3000);
    check_init_and_pass("boot");
    chk("boot_initd_sticky", init_done, 1);

    // Host writes in IDLE, then repaint.
    wr(5'd0, 8'h48);
    wr(5'd31, 8'h21);
    clear_log();
    pulse_refresh();
    chk("refresh_busy", busy, 1);
    wait_idle(3000);
    chk("ref_count", log_q.size(), 34);
    chk("ref_first_char", log_at(1), {1'b1, 8'h48});
    chk("ref_last_char", log_at(33), {1'b1, 8'h21});
    check_pass(0, "ref");

    // Multiple refresh requests mid-pass collapse into one extra pass.
    clear_log();
    pulse_refresh();
    repeat (20) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      repeat (15) @(negedge clock);
    end
    wait_idle(6000);
    chk("pend_count", log_q.size(), 68);
    check_pass(34, "pend_second");
    repeat (100) @(negedge clock);
    chk("pend_no_third", log_q.size(), 68);
    chk("pend_idle", busy, 0);

    // Write to line 2 while the pass is still early on.
    clear_log();
    pulse_refresh();
    wait_log(6, 500);
    wr(5'd20, 8'h41);
    wait_idle(3000);
    chk("midpass_idx20", log_at(22), {1'b1, 8'h41});
    check_pass(0, "midpass");

    // Reset while waiting for done to return high.
    clear_log();
    pulse_refresh();
    wait_log(3, 500);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("pre_rst_done_low", lcd_bus.lcd_done, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    repeat (3) @(negedge clock);
    clear_log();
    reset = 1'b0;
    wait_idle(3000);
    check_init_and_pass("reboot");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
